// File: rtl/calc_alu.sv
// Sequential sign-magnitude ALU: single-step add/sub, 12-step shift-add multiply
// and restoring divide/modulo behind a start/busy/done handshake.
module calc_alu #(
    parameter int MAG_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAG_W:0]     opA,
    input  logic [MAG_W:0]     opB,
    input  logic [3:0]         op,
    output logic [2*MAG_W:0]   result,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam int CW = $clog2(MAG_W);
    localparam logic [CW-1:0] LAST = CW'(MAG_W - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t               state;
    logic [MAG_W-1:0]     a_mag, b_mag;
    logic                 a_sign, b_sign;
    logic [3:0]           op_q;
    logic [CW-1:0]        cnt;
    logic [2*MAG_W-1:0]   acc;
    logic [MAG_W-1:0]     rem, quo;

    logic [2*MAG_W-1:0]   acc_next;
    logic [MAG_W:0]       rem_shift, rem_diff;
    logic [MAG_W-1:0]     rem_next, quo_next;
    logic                 eff_b_sign, as_sign;
    logic [MAG_W:0]       as_mag;
    logic [2*MAG_W-1:0]   res_mag;
    logic                 res_sign, res_err, last_step;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_next = acc;
        if (b_mag[cnt])
            acc_next = acc + ({{MAG_W{1'b0}}, a_mag} << cnt);

        // Restoring division: bring down the next dividend bit, subtract if it fits.
        rem_shift = {rem, a_mag[LAST - cnt]};
        rem_diff  = rem_shift - {1'b0, b_mag};
        if (rem_shift >= {1'b0, b_mag}) begin
            rem_next = rem_diff[MAG_W-1:0];
            quo_next = {quo[MAG_W-2:0], 1'b1};
        end else begin
            rem_next = rem_shift[MAG_W-1:0];
            quo_next = {quo[MAG_W-2:0], 1'b0};
        end

        eff_b_sign = b_sign ^ (op_q == OP_SUB);
        if (a_sign == eff_b_sign) begin
            as_mag  = {1'b0, a_mag} + {1'b0, b_mag};
            as_sign = a_sign;
        end else if (a_mag >= b_mag) begin
            as_mag  = {1'b0, a_mag} - {1'b0, b_mag};
            as_sign = a_sign;
        end else begin
            as_mag  = {1'b0, b_mag} - {1'b0, a_mag};
            as_sign = eff_b_sign;
        end

        res_mag   = '0;
        res_sign  = 1'b0;
        res_err   = 1'b0;
        last_step = 1'b1;
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_mag  = {{(MAG_W-1){1'b0}}, as_mag};
                res_sign = as_sign;
            end
            OP_MUL: begin
                last_step = (cnt == LAST);
                res_mag   = acc_next;
                res_sign  = a_sign ^ b_sign;
            end
            OP_DIV, OP_MOD: begin
                last_step = (cnt == LAST);
                if (b_mag == '0) begin
                    res_err = 1'b1;
                end else if (op_q == OP_DIV) begin
                    res_mag  = {{MAG_W{1'b0}}, quo_next};
                    res_sign = a_sign ^ b_sign;
                end else begin
                    res_mag  = {{MAG_W{1'b0}}, rem_next};
                    res_sign = a_sign;
                end
            end
            default: res_err = 1'b1;
        endcase
        // No negative zero on the output.
        res_sign = res_sign & (|res_mag);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_mag  <= '0;
            b_mag  <= '0;
            a_sign <= 1'b0;
            b_sign <= 1'b0;
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Negative zero operands are folded to +0 at capture.
                        a_mag  <= opA[MAG_W-1:0];
                        b_mag  <= opB[MAG_W-1:0];
                        a_sign <= opA[MAG_W] & (|opA[MAG_W-1:0]);
                        b_sign <= opB[MAG_W] & (|opB[MAG_W-1:0]);
                        op_q   <= op;
                        cnt    <= '0;
                        acc    <= '0;
                        rem    <= '0;
                        quo    <= '0;
                        busy   <= 1'b1;
                        error  <= 1'b0;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        result <= {res_sign, res_mag};
                        error  <= res_err;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_alu.sv
// Directed self-checking bench for calc_alu: latency, handshake, arithmetic
// results, error cases and asynchronous reset.
module tb_calc_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] opA, opB;
    logic [3:0]  op;
    logic [24:0] result;
    logic        busy, done, error;

    int n_cmp = 0;
    int n_err = 0;

    calc_alu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .opA    (opA),
        .opB    (opB),
        .op     (op),
        .result (result),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one operation, wait for done (bounded), check latency, busy span,
    // one-cycle done pulse, result and error.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [12:0] a,
                          input logic [12:0] b, input int exp_lat,
                          input logic [24:0] exp_res, input logic exp_err);
        int lat;
        int busy_cyc;
        @(negedge clk);
        op = o; opA = a; opB = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy) busy_cyc++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cyc, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_error"}, error, exp_err);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int dones;
        int lat;
        reset = 1'b1; start = 1'b0; opA = '0; opB = '0; op = '0;
        #12;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("sub", 4'b0001, 13'h0003, 13'h000A, 1, 25'h1000007, 1'b0);
        run_op("mul_neg", 4'b0010, 13'h0019, 13'h1007, 12, 25'h10000AF, 1'b0);
        run_op("mul_max", 4'b0010, 13'h0FFF, 13'h0FFF, 12, 25'h0FFE001, 1'b0);
        run_op("add_pos", 4'b0000, 13'h0FFF, 13'h0FFF, 1, 25'h0001FFE, 1'b0);
        run_op("div", 4'b0011, 13'h1064, 13'h0007, 12, 25'h100000E, 1'b0);
        run_op("mod", 4'b0100, 13'h1064, 13'h0007, 12, 25'h1000002, 1'b0);

        // Asynchronous reset in the middle of a multiply.
        @(negedge clk);
        op = 4'b0010; opA = 13'h0019; opB = 13'h1007; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_result", result, 0);
        @(negedge clk);
        reset = 1'b0;

        run_op("add_zero", 4'b0000, 13'h0005, 13'h1005, 1, 25'h0000000, 1'b0);

        run_op("div_negzero", 4'b0011, 13'h0064, 13'h1000, 12, 25'h0000000, 1'b1);
        repeat (2) @(negedge clk);
        check("err_held", error, 1);
        // Error must clear on the accept edge of the next start.
        op = 4'b0000; opA = 13'h0002; opB = 13'h0003; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("err_clear_on_accept", error, 0);
        check("err_clear_busy", busy, 1);
        @(negedge clk);
        check("add_after_err_result", result, 25'h0000005);
        check("add_after_err_done", done, 1);

        // start pulsed at t3 of a multiply must be ignored.
        @(negedge clk);
        op = 4'b0010; opA = 13'h0003; opB = 13'h0004; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 2) begin
                op = 4'b0000; opA = 13'h0100; opB = 13'h0100; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dones++;
                lat = c;
            end
        end
        check("ignored_start_dones", dones, 1);
        check("ignored_start_latency", lat, 12);
        check("ignored_start_result", result, 25'h000000C);

        run_op("invalid", 4'b1111, 13'h0012, 13'h0034, 1, 25'h0000000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
